// File: rtl/tc_product_sign_restore.sv
// Post-multiplier sign restoration: per-lane two's-complement correction of
// unsigned vedic products, then low/high half selection behind a 2-deep valid/ready pipe.
module tc_product_sign_restore #(
  parameter bit reg_output = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  opcode,
  input  logic [1:0]  precision,
  input  logic [3:0]  sign_a,
  input  logic [3:0]  sign_b,
  input  logic [63:0] product_mag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  localparam int DATA_W = 64;
  localparam int RES_W  = 32;

  // Negation stays inside each lane; flags come from the top byte of the lane.
  function automatic logic [DATA_W-1:0] negate_lanes(input logic [DATA_W-1:0] mag,
                                                     input logic [1:0] prec,
                                                     input logic [3:0] neg);
    logic [DATA_W-1:0] r;
    r = mag;
    case (prec)
      2'b01: begin
        for (int j = 0; j < 2; j++)
          if (neg[2*j+1]) r[32*j +: 32] = -$signed(mag[32*j +: 32]);
      end
      2'b10: begin
        if (neg[3]) r = -$signed(mag);
      end
      default: begin
        for (int i = 0; i < 4; i++)
          if (neg[i]) r[16*i +: 16] = -$signed(mag[16*i +: 16]);
      end
    endcase
    return r;
  endfunction

  function automatic logic [RES_W-1:0] select_half(input logic [DATA_W-1:0] p,
                                                   input logic [1:0] prec,
                                                   input logic hi);
    logic [RES_W-1:0] r;
    r = '0;
    case (prec)
      2'b01: begin
        for (int j = 0; j < 2; j++)
          r[16*j +: 16] = hi ? p[32*j+16 +: 16] : p[32*j +: 16];
      end
      2'b10: r = hi ? p[63:32] : p[31:0];
      default: begin
        for (int i = 0; i < 4; i++)
          r[8*i +: 8] = hi ? p[16*i+8 +: 8] : p[16*i +: 8];
      end
    endcase
    return r;
  endfunction

  logic [3:0]        neg_flags;
  logic [DATA_W-1:0] corr_in;
  logic [DATA_W-1:0] corr_p1;
  logic [1:0]        opcode_p1;
  logic [1:0]        prec_p1;
  logic              vld_p1;
  logic              adv_p1;
  logic              ld_p1;
  logic [RES_W-1:0]  sel_p1;

  assign neg_flags = (opcode == 2'b10) ? 4'b0000 : (sign_a ^ sign_b);
  assign corr_in   = negate_lanes(product_mag, precision, neg_flags);
  assign ld_p1     = !vld_p1 || adv_p1;
  assign in_ready  = ld_p1;

  // Stage 1: corrected lane products
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      corr_p1   <= '0;
      opcode_p1 <= '0;
      prec_p1   <= '0;
    end else if (ld_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        corr_p1   <= corr_in;
        opcode_p1 <= opcode;
        prec_p1   <= (precision == 2'b11) ? 2'b00 : precision;
      end
    end
  end

  assign sel_p1 = select_half(corr_p1, prec_p1, opcode_p1 != 2'b00);

  // Stage 2: registered select, or a pass-through when reg_output is 0
  generate
    if (reg_output) begin : g_reg_out
      logic             vld_p2;
      logic [RES_W-1:0] result_p2;

      assign adv_p1 = !vld_p2 || out_ready;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_p2    <= 1'b0;
          result_p2 <= '0;
        end else if (adv_p1) begin
          vld_p2 <= vld_p1;
          if (vld_p1) result_p2 <= sel_p1;
        end
      end

      assign out_valid = vld_p2;
      assign result    = result_p2;
    end else begin : g_comb_out
      assign adv_p1    = out_ready;
      assign out_valid = vld_p1;
      assign result    = sel_p1;
    end
  endgenerate

endmodule

// File: tb/tb_tc_product_sign_restore.sv
// Bench for tc_product_sign_restore: directed and random beats checked against
// an arithmetic lane model plus an in-order latency/occupancy scoreboard.
module tb_tc_product_sign_restore;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  opcode = '0;
  logic [1:0]  precision = '0;
  logic [3:0]  sign_a = '0;
  logic [3:0]  sign_b = '0;
  logic [63:0] product_mag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;

  tc_product_sign_restore #(.reg_output(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .precision(precision), .sign_a(sign_a), .sign_b(sign_b),
    .product_mag(product_mag), .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          acc;
    bit          has_k;
    logic [31:0] k;
  } beat_t;

  beat_t q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    acc_cnt = 0;
  bit    last_acc = 1'b0;
  bit    cur_has_k = 1'b0;
  logic [31:0] cur_k = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Lane arithmetic straight from the rules: signed correction modulo lane width.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [1:0] prec,
                                             input logic [3:0] sa, input logic [3:0] sb,
                                             input logic [63:0] mag);
    int p, nl, w, hl, idx;
    longint unsigned mask, lane, half, res;
    p    = (prec == 2'b11) ? 0 : int'(prec);
    nl   = 4 >> p;
    w    = 16 << p;
    hl   = w / 2;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    res  = 0;
    for (int k = 0; k < nl; k++) begin
      lane = (mag >> (k * w)) & mask;
      idx  = (p == 0) ? k : (p == 1) ? 2 * k + 1 : 3;
      if (op != 2'b10 && (sa[idx] ^ sb[idx])) lane = (mask - lane + 64'd1) & mask;
      half = (op == 2'b00) ? (lane & ((64'd1 << hl) - 64'd1)) : (lane >> hl);
      res  = res | (half << (k * hl));
    end
    return res[31:0];
  endfunction

  // One clock: sample mid-cycle, score, then advance past the edge.
  task automatic cycle();
    bit exp_ovld, exp_irdy;
    beat_t b;
    #4;
    last_acc = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      exp_ovld = (q.size() > 0) && (cyc >= q[0].acc + 2);
      exp_irdy = (q.size() < 2) || out_ready;
      check("out_valid", 64'(out_valid), 64'(exp_ovld));
      check("in_ready", 64'(in_ready), 64'(exp_irdy));
      if (exp_ovld) begin
        check("result", 64'(result), 64'(q[0].res));
        if (q[0].has_k) check("result_const", 64'(result), 64'(q[0].k));
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_irdy) begin
        b.res   = ref_result(opcode, precision, sign_a, sign_b, product_mag);
        b.acc   = cyc;
        b.has_k = cur_has_k;
        b.k     = cur_k;
        q.push_back(b);
        last_acc = 1'b1;
        acc_cnt++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] prec, input logic [3:0] sa,
                       input logic [3:0] sb, input logic [63:0] mag,
                       input bit hk, input logic [31:0] k);
    int n;
    opcode = op; precision = prec; sign_a = sa; sign_b = sb; product_mag = mag;
    cur_has_k = hk; cur_k = k; in_valid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("accept_timeout", 64'(n), 64'(0));
    in_valid = 1'b0; cur_has_k = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'(0));
  endtask

  initial begin
    int start;
    // Reset and idle state
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    cycle();

    // Directed lane cases
    drive(2'b00, 2'b00, 4'b0001, 4'b0000, 64'h000F, 1'b1, 32'h0000_00F1);
    drive(2'b01, 2'b00, 4'b0001, 4'b0000, 64'h000F, 1'b1, 32'h0000_00FF);
    drive(2'b00, 2'b11, 4'b0001, 4'b0000, 64'h000F, 1'b1, 32'h0000_00F1);
    drive(2'b01, 2'b10, 4'b1111, 4'b0000, 64'h0000_0001_0000_0000, 1'b1, 32'hFFFF_FFFF);
    drive(2'b00, 2'b10, 4'b1111, 4'b0000, 64'h0000_0001_0000_0000, 1'b1, 32'h0000_0000);
    drive(2'b10, 2'b01, 4'b1111, 4'b0000, 64'h0000_1234_0000_5678, 1'b1, 32'h0000_0000);
    drive(2'b01, 2'b01, 4'b1010, 4'b0000, 64'h0, 1'b1, 32'h0000_0000);
    drive(2'b00, 2'b01, 4'b0010, 4'b0000, 64'h0000_0000_0000_0003, 1'b1, 32'h0000_FFFD);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      opcode      = 2'($urandom_range(0, 3));
      precision   = 2'($urandom_range(0, 3));
      sign_a      = 4'($urandom);
      sign_b      = 4'($urandom);
      product_mag = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) product_mag = '0;
      cycle();
    end
    drain();

    // Backpressure: three beats offered while downstream stalls
    out_ready = 1'b0;
    start = acc_cnt;
    drive(2'b00, 2'b00, 4'b0011, 4'b0001, 64'h1111_2222_3333_4444, 1'b0, '0);
    drive(2'b01, 2'b01, 4'b1000, 4'b0010, 64'h0123_4567_89AB_CDEF, 1'b0, '0);
    opcode = 2'b11; precision = 2'b10; sign_a = 4'b1000; sign_b = 4'b0000;
    product_mag = 64'h0000_00FF_0000_0001; in_valid = 1'b1;
    repeat (3) cycle();
    check("bp_accepts", 64'(acc_cnt - start), 64'(2));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    for (int n = 0; n < 10 && (acc_cnt - start) < 3; n++) cycle();
    check("bp_third_accept", 64'(acc_cnt - start), 64'(3));
    drain();

    // Reset with two beats in flight; inputs during reset ignored
    out_ready = 1'b0;
    drive(2'b00, 2'b00, 4'b0001, 4'b0000, 64'h00AA, 1'b0, '0);
    drive(2'b01, 2'b00, 4'b0001, 4'b0000, 64'h00BB, 1'b0, '0);
    in_valid = 1'b1; product_mag = 64'h00CC;
    rst = 1'b1;
    cycle();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    repeat (6) cycle();
    check("rst_no_stale", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
